// File: rtl/decode_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// decode_hazard_ctrl
//
// Scoreboard-based hazard controller for the decode stage. One small counter
// per architectural register tracks how many issued writers have not yet
// reached writeback. Decode stalls while any source it reads is still pending.
// A redirect resolved in decode clears F/D and marks the next decode
// instruction as wrong-path (kill). That instruction is turned into a bubble
// and never touches the scoreboard.
//
// Optional feature macro: DECODE_HAZARD_WB_BYPASS_EN
//   When defined, a register whose only pending writer is being written back
//   in the current cycle counts as ready. The register file forwards that
//   write data to the same-cycle read.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   valid_D                  decode holds a real instruction
//   Rs1_D/Rs2_D, useRs*_D    source addresses and whether they are read
//   regWrite_D, Rd_D         decode instruction writes Rd_D
//   PCsrc_D                  redirect resolved in decode
//   regWrite_W, Rd_W         writeback port (same as register file)
//   extStall                 global freeze
//   stall_F, stall_D         hold PC and F/D register
//   flush_E                  load a bubble into D/E
//   flush_FD                 clear the F/D register
//   issue_D                  decode instruction advances this cycle
//   stallCount               hazard stall cycles since reset (wraps)
//   sbErr                    sticky scoreboard over/underflow
// ---------------------------------------------------------------------------
module decode_hazard_ctrl #(
   parameter int NREG         = 32,
   parameter int RA_W         = 5,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_D,
   input  logic [RA_W-1:0] Rs1_D,
   input  logic [RA_W-1:0] Rs2_D,
   input  logic            useRs1_D,
   input  logic            useRs2_D,
   input  logic            regWrite_D,
   input  logic [RA_W-1:0] Rd_D,
   input  logic            PCsrc_D,
   input  logic            regWrite_W,
   input  logic [RA_W-1:0] Rd_W,
   input  logic            extStall,
   output logic            stall_F,
   output logic            stall_D,
   output logic            flush_E,
   output logic            flush_FD,
   output logic            issue_D,
   output logic [31:0]     stallCount,
   output logic            sbErr
);

   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   typedef enum logic [1:0] {RUN, HAZ, REDIR} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q [NREG];
   logic [CW-1:0]   cnt_d [NREG];
   logic [NREG-1:0] incVec, decVec;
   logic [31:0]     stallCount_q;
   logic            sbErr_q, sbErrSet;
   logic            kill, pend1, pend2, hazard, issue;

   // The cycle after a redirect, decode holds a wrong-path instruction.
   assign kill = (state_q == REDIR);

   // A source is pending while any issued writer has not retired.
   // With the bypass, the last writer retiring this cycle forwards its
   // data through the register file, so the source counts as ready.
`ifdef DECODE_HAZARD_WB_BYPASS_EN
   assign pend1 = (cnt_q[Rs1_D] != '0) &
                  ~((cnt_q[Rs1_D] == CW'(1)) & regWrite_W & (Rd_W == Rs1_D));
   assign pend2 = (cnt_q[Rs2_D] != '0) &
                  ~((cnt_q[Rs2_D] == CW'(1)) & regWrite_W & (Rd_W == Rs2_D));
`else
   assign pend1 = (cnt_q[Rs1_D] != '0);
   assign pend2 = (cnt_q[Rs2_D] != '0);
`endif

   assign hazard = valid_D & ~kill &
                   ((useRs1_D & (Rs1_D != '0) & pend1) |
                    (useRs2_D & (Rs2_D != '0) & pend2));
   assign issue  = valid_D & ~kill & ~hazard & ~extStall;

   // Pipeline controls are forced quiet while reset is held.
   assign stall_F    = ~rst & (hazard | extStall);
   assign stall_D    = ~rst & (hazard | extStall);
   assign flush_E    = ~rst & (hazard | kill) & ~extStall;
   assign flush_FD   = ~rst & issue & PCsrc_D;
   assign issue_D    = ~rst & issue;
   assign stallCount = stallCount_q;
   assign sbErr      = sbErr_q;

   // Per-register increment/decrement requests; x0 is never tracked.
   always_comb begin
      incVec = '0;
      decVec = '0;
      for (int r = 1; r < NREG; r++) begin
         incVec[r] = issue & regWrite_D & (Rd_D == RA_W'(r));
         decVec[r] = regWrite_W & (Rd_W == RA_W'(r));
      end
   end

   // Scoreboard next state. A simultaneous issue and retire of the same
   // register cancel out. Overflow saturates and underflow is ignored;
   // both raise the sticky error.
   always_comb begin
      sbErrSet = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         case ({incVec[r], decVec[r]})
            2'b10: begin
               if (cnt_q[r] == CW'(MAX_INFLIGHT)) sbErrSet = 1'b1;
               else                               cnt_d[r] = cnt_q[r] + CW'(1);
            end
            2'b01: begin
               if (cnt_q[r] == '0) sbErrSet = 1'b1;
               else                cnt_d[r] = cnt_q[r] - CW'(1);
            end
            default: ;
         endcase
      end
   end

   // FSM next state. A redirecting issue wins from any state. REDIR lasts
   // one unfrozen cycle so exactly one wrong-path instruction is killed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (hazard & ~extStall) state_d = HAZ;
         HAZ:     if (~hazard)            state_d = RUN;
         REDIR:   if (~extStall)          state_d = RUN;
         default:                         state_d = RUN;
      endcase
      if (issue & PCsrc_D) state_d = REDIR;
   end

   // State, scoreboard, statistics and error flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         stallCount_q <= '0;
         sbErr_q      <= 1'b0;
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         state_q <= state_d;
         if (hazard & ~extStall) stallCount_q <= stallCount_q + 32'd1;
         if (sbErrSet)           sbErr_q      <= 1'b1;
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      end
   end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_hazard_ctrl
//
// Self-checking bench for decode_hazard_ctrl. Each scenario builds a plan of
// decode-stage cycles. Each cycle carries the inputs and the outputs expected
// for that cycle. applyStimulus drives a cycle and pushes its expectation
// into a scoreboard queue. The scenario pops the queue once the outputs have
// settled and compares against the DUT.
// Expectations that depend on the writeback bypass follow
// DECODE_HAZARD_WB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_decode_hazard_ctrl;

   typedef struct {
      bit          rst, valid, use1, use2, rw, pc, rwW, ext;
      bit [4:0]    rs1, rs2, rd, rdW;
      bit [5:0]    eFlags;
      int unsigned eCount;
   } step_t;

   logic        clk, rst, valid_D, useRs1_D, useRs2_D, regWrite_D, PCsrc_D;
   logic        regWrite_W, extStall;
   logic [4:0]  Rs1_D, Rs2_D, Rd_D, Rd_W;
   logic        stall_F, stall_D, flush_E, flush_FD, issue_D, sbErr;
   logic [31:0] stallCount;

   step_t scoreQ [$];
   int    nChecks = 0;
   int    nErrors = 0;

   decode_hazard_ctrl dut (
      .clk(clk), .rst(rst), .valid_D(valid_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
      .useRs1_D(useRs1_D), .useRs2_D(useRs2_D), .regWrite_D(regWrite_D),
      .Rd_D(Rd_D), .PCsrc_D(PCsrc_D), .regWrite_W(regWrite_W), .Rd_W(Rd_W),
      .extStall(extStall), .stall_F(stall_F), .stall_D(stall_D),
      .flush_E(flush_E), .flush_FD(flush_FD), .issue_D(issue_D),
      .stallCount(stallCount), .sbErr(sbErr)
   );

   // Free-running clock: rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build one cycle. Sources < 0 are unused, wb < 0 means no writeback.
   // Expected flags are stall, flush_E, flush_FD, issue_D and sbErr.
   function automatic step_t mk(bit v, int r1, int r2, bit rw, int rd, bit pc,
                                int wb, bit ext, bit eSt, bit eFE, bit eFFD,
                                bit eIss, bit eErr, int unsigned eCnt);
      step_t s;
      s.rst    = 1'b0;
      s.valid  = v;
      s.use1   = (r1 >= 0);
      s.rs1    = (r1 >= 0) ? r1[4:0] : 5'd0;
      s.use2   = (r2 >= 0);
      s.rs2    = (r2 >= 0) ? r2[4:0] : 5'd0;
      s.rw     = rw;
      s.rd     = rd[4:0];
      s.pc     = pc;
      s.rwW    = (wb >= 0);
      s.rdW    = (wb >= 0) ? wb[4:0] : 5'd0;
      s.ext    = ext;
      s.eFlags = {eSt, eSt, eFE, eFFD, eIss, eErr};
      s.eCount = eCnt;
      return s;
   endfunction

   // Drive one decode cycle just after the falling edge, queue its
   // expectation, then leave time for the combinational outputs to settle.
   task automatic applyStimulus(input step_t s);
      @(negedge clk);
      rst        = s.rst;
      valid_D    = s.valid;
      Rs1_D      = s.rs1;
      useRs1_D   = s.use1;
      Rs2_D      = s.rs2;
      useRs2_D   = s.use2;
      regWrite_D = s.rw;
      Rd_D       = s.rd;
      PCsrc_D    = s.pc;
      regWrite_W = s.rwW;
      Rd_W       = s.rdW;
      extStall   = s.ext;
      scoreQ.push_back(s);
      #1;
   endtask

   // One reset cycle with idle inputs; the next step releases it.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; valid_D = 1'b0; regWrite_W = 1'b0; extStall = 1'b0;
      PCsrc_D = 1'b0; regWrite_D = 1'b0;
   endtask

   // Reset with random inputs, release, then reset during REDIR while frozen.
   task automatic test_reset();
      step_t plan [$];
      step_t s, e;
      logic [5:0] got;
      for (int i = 0; i < 2; i++) begin
         s = mk($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                $urandom_range(0, 31), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0);
         s.rst = 1'b1;
         plan.push_back(s);
      end
      plan.push_back(mk(1, 3, 4, 1, 10, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      plan.push_back(mk(1, -1, -1, 1, 5, 1, -1, 0, 0, 0, 1, 1, 0, 0));
      s = mk(1, 5, -1, 0, 0, 0, -1, 1, 0, 0, 0, 0, 0, 0);
      s.rst = 1'b1;
      plan.push_back(s);
      plan.push_back(mk(1, 5, 10, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i < plan.size(); i++) begin
         applyStimulus(plan[i]);
         e   = scoreQ.pop_front();
         got = {stall_F, stall_D, flush_E, flush_FD, issue_D, sbErr};
         nChecks++;
         if (got !== e.eFlags) begin
            nErrors++;
            $display("[TB] FAIL reset step %0d flags{stF,stD,flE,flFD,iss,err}: got %b want %b", i, got, e.eFlags);
         end
         nChecks++;
         if (stallCount !== e.eCount) begin
            nErrors++;
            $display("[TB] FAIL reset step %0d stallCount: got %0d want %0d", i, stallCount, e.eCount);
         end
      end
   endtask

   // Producer of x5, dependent consumer, writeback three cycles later.
   task automatic test_raw();
      step_t plan [$];
      step_t e;
      logic [5:0] got;
      doReset();
      plan.push_back(mk(1, 0, -1, 1, 5, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      plan.push_back(mk(1, 5, -1, 1, 6, 0, -1, 0, 1, 1, 0, 0, 0, 0));
      plan.push_back(mk(1, 5, -1, 1, 6, 0, -1, 0, 1, 1, 0, 0, 0, 1));
`ifdef DECODE_HAZARD_WB_BYPASS_EN
      plan.push_back(mk(1, 5, -1, 1, 6, 0, 5, 0, 0, 0, 0, 1, 0, 2));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 2));
      plan.push_back(mk(1, 6, -1, 0, 0, 0, -1, 0, 1, 1, 0, 0, 0, 2));
`else
      plan.push_back(mk(1, 5, -1, 1, 6, 0, 5, 0, 1, 1, 0, 0, 0, 2));
      plan.push_back(mk(1, 5, -1, 1, 6, 0, -1, 0, 0, 0, 0, 1, 0, 3));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 3));
      plan.push_back(mk(1, 6, -1, 0, 0, 0, -1, 0, 1, 1, 0, 0, 0, 3));
`endif
      for (int i = 0; i < plan.size(); i++) begin
         applyStimulus(plan[i]);
         e   = scoreQ.pop_front();
         got = {stall_F, stall_D, flush_E, flush_FD, issue_D, sbErr};
         nChecks++;
         if (got !== e.eFlags) begin
            nErrors++;
            $display("[TB] FAIL raw step %0d flags{stF,stD,flE,flFD,iss,err}: got %b want %b", i, got, e.eFlags);
         end
         nChecks++;
         if (stallCount !== e.eCount) begin
            nErrors++;
            $display("[TB] FAIL raw step %0d stallCount: got %0d want %0d", i, stallCount, e.eCount);
         end
      end
   endtask

   // Two back-to-back writers of x7; the reader waits for both writebacks.
   task automatic test_double_writer();
      step_t plan [$];
      step_t e;
      logic [5:0] got;
      doReset();
      plan.push_back(mk(1, -1, -1, 1, 7, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      plan.push_back(mk(1, -1, -1, 1, 7, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      plan.push_back(mk(1, -1, 7, 0, 0, 0, -1, 0, 1, 1, 0, 0, 0, 0));
      plan.push_back(mk(1, -1, 7, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0, 1));
      plan.push_back(mk(1, -1, 7, 0, 0, 0, -1, 0, 1, 1, 0, 0, 0, 2));
`ifdef DECODE_HAZARD_WB_BYPASS_EN
      plan.push_back(mk(1, -1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 3));
`else
      plan.push_back(mk(1, -1, 7, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0, 3));
      plan.push_back(mk(1, -1, 7, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 4));
`endif
      for (int i = 0; i < plan.size(); i++) begin
         applyStimulus(plan[i]);
         e   = scoreQ.pop_front();
         got = {stall_F, stall_D, flush_E, flush_FD, issue_D, sbErr};
         nChecks++;
         if (got !== e.eFlags) begin
            nErrors++;
            $display("[TB] FAIL double step %0d flags{stF,stD,flE,flFD,iss,err}: got %b want %b", i, got, e.eFlags);
         end
         nChecks++;
         if (stallCount !== e.eCount) begin
            nErrors++;
            $display("[TB] FAIL double step %0d stallCount: got %0d want %0d", i, stallCount, e.eCount);
         end
      end
   endtask

   // Redirect: the killed instruction reads pending x4 and writes x9.
   task automatic test_redirect();
      step_t plan [$];
      step_t e;
      logic [5:0] got;
      doReset();
      plan.push_back(mk(1, -1, -1, 1, 4, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      plan.push_back(mk(1, -1, -1, 0, 0, 1, -1, 0, 0, 0, 1, 1, 0, 0));
      plan.push_back(mk(1, 4, -1, 1, 9, 0, -1, 0, 0, 1, 0, 0, 0, 0));
      plan.push_back(mk(1, 9, -1, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      plan.push_back(mk(1, 4, -1, 0, 0, 0, -1, 0, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < plan.size(); i++) begin
         applyStimulus(plan[i]);
         e   = scoreQ.pop_front();
         got = {stall_F, stall_D, flush_E, flush_FD, issue_D, sbErr};
         nChecks++;
         if (got !== e.eFlags) begin
            nErrors++;
            $display("[TB] FAIL redirect step %0d flags{stF,stD,flE,flFD,iss,err}: got %b want %b", i, got, e.eFlags);
         end
         nChecks++;
         if (stallCount !== e.eCount) begin
            nErrors++;
            $display("[TB] FAIL redirect step %0d stallCount: got %0d want %0d", i, stallCount, e.eCount);
         end
      end
   endtask

   // Four frozen cycles during a RAW hazard, with writeback while frozen.
   task automatic test_freeze();
      step_t plan [$];
      step_t e;
      logic [5:0] got;
      doReset();
      plan.push_back(mk(1, -1, -1, 1, 5, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, -1, 0, 1, 1, 0, 0, 0, 0));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, -1, 1, 1, 0, 0, 0, 0, 1));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, -1, 1, 1, 0, 0, 0, 0, 1));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, -1, 1, 1, 0, 0, 0, 0, 1));
      plan.push_back(mk(1, 5, -1, 0, 0, 0, -1, 0, 0, 0, 0, 1, 0, 1));
      for (int i = 0; i < plan.size(); i++) begin
         applyStimulus(plan[i]);
         e   = scoreQ.pop_front();
         got = {stall_F, stall_D, flush_E, flush_FD, issue_D, sbErr};
         nChecks++;
         if (got !== e.eFlags) begin
            nErrors++;
            $display("[TB] FAIL freeze step %0d flags{stF,stD,flE,flFD,iss,err}: got %b want %b", i, got, e.eFlags);
         end
         nChecks++;
         if (stallCount !== e.eCount) begin
            nErrors++;
            $display("[TB] FAIL freeze step %0d stallCount: got %0d want %0d", i, stallCount, e.eCount);
         end
      end
   endtask

   // Underflow on x3, x0 writes and reads, reset clearing the sticky error,
   // then overflow on x8 followed by a full drain.
   task automatic test_errors();
      step_t plan [$];
      step_t s, e;
      logic [5:0] got;
      doReset();
      plan.push_back(mk(0, -1, -1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
      plan.push_back(mk(0, -1, -1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 1, 0));
      plan.push_back(mk(1, -1, -1, 1, 0, 0, -1, 0, 0, 0, 0, 1, 1, 0));
      plan.push_back(mk(1, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 1, 1, 0));
      s = mk(0, -1, -1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 1, 0);
      s.rst = 1'b1;
      plan.push_back(s);
      plan.push_back(mk(0, -1, -1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 4; k++)
         plan.push_back(mk(1, -1, -1, 1, 8, 0, -1, 0, 0, 0, 0, 1, 0, 0));
      for (int k = 0; k < 3; k++)
         plan.push_back(mk(0, -1, -1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0));
      plan.push_back(mk(1, 8, -1, 0, 0, 0, -1, 0, 0, 0, 0, 1, 1, 0));
      for (int i = 0; i < plan.size(); i++) begin
         applyStimulus(plan[i]);
         e   = scoreQ.pop_front();
         got = {stall_F, stall_D, flush_E, flush_FD, issue_D, sbErr};
         nChecks++;
         if (got !== e.eFlags) begin
            nErrors++;
            $display("[TB] FAIL errors step %0d flags{stF,stD,flE,flFD,iss,err}: got %b want %b", i, got, e.eFlags);
         end
         nChecks++;
         if (stallCount !== e.eCount) begin
            nErrors++;
            $display("[TB] FAIL errors step %0d stallCount: got %0d want %0d", i, stallCount, e.eCount);
         end
      end
   endtask

   initial begin
      rst = 1'b1; valid_D = 1'b0; Rs1_D = '0; Rs2_D = '0; useRs1_D = 1'b0;
      useRs2_D = 1'b0; regWrite_D = 1'b0; Rd_D = '0; PCsrc_D = 1'b0;
      regWrite_W = 1'b0; Rd_W = '0; extStall = 1'b0;
      $display("[TB] decode_hazard_ctrl bench start");
      test_reset();
      test_raw();
      test_double_writer();
      test_redirect();
      test_freeze();
      test_errors();
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
